// File: rtl/serial_word_receiver.sv
// Serial frame deserialiser: start, N data bits, optional parity, stop.
// Delivers each word through a single-entry valid/ready holding buffer.
module serial_word_receiver #(
   parameter int N          = 4,
   parameter bit PARITY_EN  = 1'b1,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         sin,
   input  logic         sin_en,
   output logic [N-1:0] dout,
   output logic         dout_valid,
   input  logic         dout_ready,
   output logic         parity_err,
   output logic         frame_err,
   output logic         overrun,
   input  logic         ovr_clr
);

   localparam int CW = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [N-1:0]  acc;
   logic          par;
   logic          perr;
   logic          can_load;

   assign perr     = PARITY_EN && ((^acc ^ par) != PARITY_ODD);
   assign can_load = !dout_valid || dout_ready;

   // Later assignments in this block override earlier defaults, which
   // gives buffer-write priority over drain and overrun-set over clear.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state      <= IDLE;
         cnt        <= '0;
         acc        <= '0;
         par        <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (ovr_clr)
            overrun <= 1'b0;
         if (dout_valid && dout_ready)
            dout_valid <= 1'b0;
         if (sin_en) begin
            unique case (state)
               IDLE: begin
                  if (!sin) begin
                     state <= DATA;
                     cnt   <= '0;
                     acc   <= '0;
                     par   <= 1'b0;
                  end
               end
               DATA: begin
                  acc <= {acc[N-2:0], sin};
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     if (PARITY_EN)
                        state <= PARITY;
                     else
                        state <= STOP;
                  end
               end
               PARITY: begin
                  par   <= sin;
                  state <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (sin) begin
                     if (can_load) begin
                        dout       <= acc;
                        parity_err <= perr;
                        dout_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: even- and odd-parity instances share
// stimulus and are checked against a frame-level buffer model.
module tb_serial_word_receiver;

   logic       clk = 1'b0;
   logic       clr;
   logic       sin;
   logic       sin_en;
   logic       dout_ready;
   logic       ovr_clr;
   logic [3:0] dout_e, dout_o;
   logic       valid_e, valid_o;
   logic       perr_e, perr_o;
   logic       fe_e, fe_o;
   logic       ovr_e, ovr_o;

   logic       m_valid;
   logic [3:0] m_dout;
   logic       m_pe, m_po, m_ovr;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   serial_word_receiver #(.N(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_e (
      .clk(clk), .clr(clr), .sin(sin), .sin_en(sin_en),
      .dout(dout_e), .dout_valid(valid_e), .dout_ready(dout_ready),
      .parity_err(perr_e), .frame_err(fe_e), .overrun(ovr_e),
      .ovr_clr(ovr_clr)
   );

   serial_word_receiver #(.N(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_o (
      .clk(clk), .clr(clr), .sin(sin), .sin_en(sin_en),
      .dout(dout_o), .dout_valid(valid_o), .dout_ready(dout_ready),
      .parity_err(perr_o), .frame_err(fe_o), .overrun(ovr_o),
      .ovr_clr(ovr_clr)
   );

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".dout"}, {4'b0, dout_e}, {4'b0, m_dout});
      chk({tag, ".valid"}, {7'b0, valid_e}, {7'b0, m_valid});
      chk({tag, ".perr_even"}, {7'b0, perr_e}, {7'b0, m_pe});
      chk({tag, ".perr_odd"}, {7'b0, perr_o}, {7'b0, m_po});
      chk({tag, ".overrun"}, {7'b0, ovr_e}, {7'b0, m_ovr});
      chk({tag, ".dout_odd"}, {4'b0, dout_o}, {4'b0, m_dout});
      chk({tag, ".valid_odd"}, {7'b0, valid_o}, {7'b0, m_valid});
      chk({tag, ".ovr_odd"}, {7'b0, ovr_o}, {7'b0, m_ovr});
   endtask

   task automatic strobe(input logic b);
      @(negedge clk);
      sin    = b;
      sin_en = 1'b1;
      @(posedge clk);
   endtask

   task automatic gapfill(input int gap);
      repeat (gap) begin
         @(negedge clk);
         sin_en = 1'b0;
         sin    = 1'($urandom);
         @(posedge clk);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         sin_en     = 1'b0;
         sin        = 1'($urandom);
         dout_ready = 1'b0;
         ovr_clr    = 1'b0;
         @(posedge clk);
      end
      #1;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      sin_en = 1'b0;
      clr    = 1'b1;
      #1;
      m_valid = 1'b0;
      m_dout  = 4'h0;
      m_pe    = 1'b0;
      m_po    = 1'b0;
      m_ovr   = 1'b0;
      check_all(tag);
      chk({tag, ".fe"}, {7'b0, fe_e}, 8'h0);
      @(negedge clk);
      clr = 1'b0;
   endtask

   // One frame; rs/oc drive dout_ready/ovr_clr on the stop-bit edge.
   task automatic send(input string tag, input logic [3:0] d,
                       input logic p, input logic s, input int gap,
                       input logic rs, input logic oc);
      strobe(1'b0);
      gapfill(gap);
      for (int i = 3; i >= 0; i--) begin
         strobe(d[i]);
         gapfill(gap);
      end
      strobe(p);
      gapfill(gap);
      @(negedge clk);
      sin        = s;
      sin_en     = 1'b1;
      dout_ready = rs;
      ovr_clr    = oc;
      chk({tag, ".valid_pre"}, {7'b0, valid_e}, {7'b0, m_valid});
      @(posedge clk);
      #1;
      if (oc)
         m_ovr = 1'b0;
      if (s) begin
         if (!m_valid || rs) begin
            m_valid = 1'b1;
            m_dout  = d;
            m_pe    = ^d ^ p;
            m_po    = ~m_pe;
         end else begin
            m_ovr = 1'b1;
         end
      end else if (rs) begin
         m_valid = 1'b0;
      end
      check_all(tag);
      chk({tag, ".fe"}, {7'b0, fe_e}, {7'b0, ~s});
      chk({tag, ".fe_odd"}, {7'b0, fe_o}, {7'b0, ~s});
      idle(1);
      chk({tag, ".fe_after"}, {7'b0, fe_e}, 8'h0);
   endtask

   task automatic consume(input string tag);
      @(negedge clk);
      sin_en     = 1'b0;
      dout_ready = 1'b1;
      @(posedge clk);
      #1;
      m_valid = 1'b0;
      check_all(tag);
      idle(1);
   endtask

   task automatic pulse_ovr_clr(input string tag);
      @(negedge clk);
      sin_en  = 1'b0;
      ovr_clr = 1'b1;
      @(posedge clk);
      #1;
      m_ovr = 1'b0;
      check_all(tag);
      idle(1);
   endtask

   initial begin
      clr        = 1'b1;
      sin        = 1'b1;
      sin_en     = 1'b0;
      dout_ready = 1'b0;
      ovr_clr    = 1'b0;
      m_valid    = 1'b0;
      m_dout     = 4'h0;
      m_pe       = 1'b0;
      m_po       = 1'b0;
      m_ovr      = 1'b0;
      #1;
      check_all("reset0");
      chk("reset0.fe", {7'b0, fe_e}, 8'h0);
      @(negedge clk);
      clr = 1'b0;
      idle(2);

      // abort a frame after two data bits
      strobe(1'b0);
      strobe(1'b1);
      strobe(1'b0);
      do_reset("reset_mid");
      send("after_reset", 4'b1011, 1'b1, 1'b1, 0, 1'b0, 1'b0);
      consume("drain1");

      send("parity_bad", 4'b1011, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      consume("drain2");

      send("frame_err", 4'b1110, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      send("after_fe", 4'b0110, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      consume("drain3");

      send("ovr_first", 4'b0011, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      send("ovr_drop", 4'b1100, 1'b0, 1'b1, 0, 1'b0, 1'b1);
      pulse_ovr_clr("ovr_clr");

      send("drain_write", 4'b1001, 1'b0, 1'b1, 0, 1'b1, 1'b0);

      do_reset("reset_full");

      send("sparse", 4'b0101, 1'b0, 1'b1, 2, 1'b0, 1'b0);
      consume("drain4");

      for (int k = 0; k < 25; k++) begin
         send("rand", 4'($urandom), 1'($urandom),
              ($urandom_range(0, 5) != 0), $urandom_range(0, 2),
              1'($urandom), ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 2) == 0)
            consume("rand_drain");
         if ($urandom_range(0, 3) == 0)
            pulse_ovr_clr("rand_oclr");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
